// File: rtl/mem_write_controller.sv
// Store-path memory controller: decodes SB/SH/SW, builds byte lanes, routes to DMEM/IMEM/IO.
// Optional store error counter is compiled in with `define MEM_WR_ERR_CNT_EN.
module mem_write_controller #(
  parameter int DMEM_AW       = 14,
  parameter int IMEM_AW       = 14,
  parameter int IO_FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               store_valid,
  input  logic [31:0]        instruction,
  input  logic [31:0]        mem_addr,
  input  logic [31:0]        store_data,
  output logic               stall,
  output logic [3:0]         dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [31:0]        dmem_din,
  output logic [3:0]         imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_din,
  output logic               io_wr_valid,
  input  logic               io_wr_ready,
  output logic [31:0]        io_wr_addr,
  output logic [31:0]        io_wr_data,
  output logic [3:0]         io_wr_be
`ifdef MEM_WR_ERR_CNT_EN
  ,
  output logic [15:0]        err_count
`endif
);

  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam int PTR_W = (IO_FIFO_DEPTH > 1) ? $clog2(IO_FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(IO_FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(IO_FIFO_DEPTH);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [1:0]  off;
  logic [3:0]  region;
  logic [15:0] half;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign off    = mem_addr[1:0];
  assign region = mem_addr[31:28];
  assign half   = store_data[15:0];

  logic unused_instr_bits;
  assign unused_instr_bits = &{1'b0, instruction[31:15], instruction[11:7]};

  // region 0011 deliberately decodes as both DMEM and IMEM
  logic dmem_hit, imem_hit, io_hit, unmapped;
  assign dmem_hit = (region[3:2] == 2'b00) && region[0];
  assign imem_hit = (region[3:1] == 3'b001);
  assign io_hit   = (region == 4'b1000);
  assign unmapped = !dmem_hit && !imem_hit && !io_hit;

  logic [3:0]  be;
  logic [31:0] wdata;
  logic        f3_legal;

  always_comb begin
    be       = 4'b0000;
    wdata    = 32'h0;
    f3_legal = 1'b1;
    case (funct3)
      3'b000: begin
        be    = 4'b0001 << off;
        wdata = {4{store_data[7:0]}};
      end
      3'b001: begin
        case (off)
          2'b00:   begin be = 4'b0011; wdata = {16'h0, half};       end
          2'b01:   begin be = 4'b0110; wdata = {8'h0, half, 8'h0};  end
          2'b10:   begin be = 4'b1100; wdata = {half, 16'h0};       end
          default: begin be = 4'b0011; wdata = {16'h0, half};       end
        endcase
      end
      3'b010: begin
        be    = 4'b1111;
        wdata = store_data;
      end
      default: f3_legal = 1'b0;
    endcase
  end

  logic [CNT_W-1:0] fifo_cnt;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             fifo_full, fifo_empty;
  logic             is_store, accepted, pop, push;
  logic             dmem_wr, imem_wr;

  assign fifo_full  = (fifo_cnt == CNT_FULL);
  assign fifo_empty = (fifo_cnt == '0);
  assign pop        = !fifo_empty && io_wr_ready;

  // a full FIFO still takes a push when the head leaves on the same edge
  assign is_store = store_valid && (opcode == OP_STORE);
  assign stall    = is_store && io_hit && fifo_full && !pop;
  assign accepted = is_store && !stall;

  assign dmem_wr = accepted && f3_legal && dmem_hit;
  assign imem_wr = accepted && f3_legal && imem_hit;
  assign push    = accepted && f3_legal && io_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_we   <= 4'b0000;
      dmem_addr <= '0;
      dmem_din  <= 32'h0;
    end else begin
      dmem_we <= dmem_wr ? be : 4'b0000;
      if (dmem_wr) begin
        dmem_addr <= mem_addr[DMEM_AW+1:2];
        dmem_din  <= wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_we   <= 4'b0000;
      imem_addr <= '0;
      imem_din  <= 32'h0;
    end else begin
      imem_we <= imem_wr ? be : 4'b0000;
      if (imem_wr) begin
        imem_addr <= mem_addr[IMEM_AW+1:2];
        imem_din  <= wdata;
      end
    end
  end

  logic [31:0] fifo_addr [IO_FIFO_DEPTH];
  logic [31:0] fifo_data [IO_FIFO_DEPTH];
  logic [3:0]  fifo_be   [IO_FIFO_DEPTH];

  // storage needs no reset: the occupancy counter defines which entries are live
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= mem_addr;
      fifo_data[wr_ptr] <= wdata;
      fifo_be[wr_ptr]   <= be;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign io_wr_valid = !fifo_empty;
  assign io_wr_addr  = fifo_empty ? 32'h0 : fifo_addr[rd_ptr];
  assign io_wr_data  = fifo_empty ? 32'h0 : fifo_data[rd_ptr];
  assign io_wr_be    = fifo_empty ? 4'b0000 : fifo_be[rd_ptr];

`ifdef MEM_WR_ERR_CNT_EN
  logic err_event;
  assign err_event = accepted && (!f3_legal || unmapped);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= 16'h0;
    end else if (err_event && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'h1;
    end
  end
`else
  logic unused_err_terms;
  assign unused_err_terms = &{1'b0, unmapped};
`endif

endmodule
